// File: rtl/core_pkg.sv
// Shared core definitions: data widths, fetch FSM encoding, and the buffered
// fetch entry layout.
package core_pkg;

    localparam int Xlen      = 32;
    localparam int InstWidth = 32;

    typedef enum logic [0:0] {
        SBoot = 1'b0,
        SRun  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [Xlen-1:0]      pc;
        logic [InstWidth-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; low two bits are discarded.
    function automatic logic [Xlen-1:0] word_align(input logic [Xlen-1:0] addr);
        return addr & {{(Xlen-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Circular FIFO of {pc, inst} fetch entries with push, pop, flush and an
// occupancy count. Flush has priority over any same-cycle push or pop.
module fetch_buf
    import core_pkg::*;
#(
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CntW-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop_s;

    assign pop_s = pop_i && (count_q != {CntW{1'b0}});

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PtrW{1'b0}};
            tail_d  = {PtrW{1'b0}};
            count_d = {CntW{1'b0}};
        end else begin
            if (push_i) begin
                tail_d = (tail_q == LastIdx) ? {PtrW{1'b0}} : tail_q + PtrW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = (head_q == LastIdx) ? {PtrW{1'b0}} : head_q + PtrW'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_i, pop_s})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= {PtrW{1'b0}};
            tail_q  <= {PtrW{1'b0}};
            count_q <= {CntW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_chk.sv
// Protocol checks for the fetch stage: no buffer overflow, and never more
// responses marked for discard than are actually outstanding.
module fetch_chk #(
    parameter int Depth = 2,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            push_i,
    input logic            pop_i,
    input logic [CntW-1:0] count_i,
    input logic [CntW-1:0] drop_i,
    input logic [CntW-1:0] outstanding_i
);

    // Sampled at each edge outside reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && !pop_i && (count_i == CntW'(Depth))))
                else $error("fetch_chk: response written into a full buffer");
            assert (drop_i <= outstanding_i)
                else $error("fetch_chk: drop count exceeds outstanding count");
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC ownership, credit-limited in-order requests,
// redirect handling with stale-response discard, and a small output buffer.
// Optional FETCH_BYPASS_EN presents a kept response directly when the buffer is empty.
module fetch
    import core_pkg::*;
#(
    parameter logic [Xlen-1:0] ResetVector = {Xlen{1'b0}},
    parameter int              Depth       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 trap_i,
    input  logic [Xlen-1:0]      trap_vector_i,
    input  logic                 branch_i,
    input  logic [Xlen-1:0]      branch_target_i,
    output logic                 imem_req_valid_o,
    input  logic                 imem_req_ready_i,
    output logic [Xlen-1:0]      imem_req_addr_o,
    input  logic                 imem_resp_valid_i,
    input  logic [InstWidth-1:0] imem_resp_data_i,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i,
    output logic [InstWidth-1:0] inst_o,
    output logic [Xlen-1:0]      inst_pc_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int SumW = CntW + 1;

    fetch_state_e    state_q, state_d;
    logic [Xlen-1:0] pc_q, pc_d;
    logic [Xlen-1:0] tail_pc_q, tail_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;

    logic            redirect_s;
    logic [Xlen-1:0] target_s;
    logic [SumW-1:0] credit_used_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            resp_keep_s;
    logic            inst_valid_s;
    logic            buf_push_s;
    logic            buf_pop_s;
    logic [CntW-1:0] buf_count_s;
    fetch_entry_t    buf_head_s;
    fetch_entry_t    resp_entry_s;

    // Redirect select; the trap unit wins over branch resolution.
    always_comb begin
        redirect_s = trap_i || branch_i;
        if (trap_i) begin
            target_s = word_align(trap_vector_i);
        end else begin
            target_s = word_align(branch_target_i);
        end
    end

    // Credit counts every slot a response could still need: in-flight kept
    // responses plus buffered entries must never exceed the buffer depth.
    always_comb begin
        credit_used_s = SumW'(outstanding_q) - SumW'(drop_q) + SumW'(buf_count_s);
        req_valid_s   = (state_q == SRun) && !redirect_s && (credit_used_s < SumW'(Depth));
        req_fire_s    = req_valid_s && imem_req_ready_i;
        resp_keep_s   = imem_resp_valid_i && (drop_q == {CntW{1'b0}}) && !redirect_s;
    end

    assign resp_entry_s = '{pc: tail_pc_q, inst: imem_resp_data_i};

`ifdef FETCH_BYPASS_EN
    logic bypass_s;

    // Empty buffer: a kept response goes straight out, and skips the buffer if consumed.
    always_comb begin
        bypass_s     = resp_keep_s && (buf_count_s == {CntW{1'b0}});
        inst_valid_s = ((buf_count_s != {CntW{1'b0}}) || bypass_s) && !redirect_s;
        buf_push_s   = resp_keep_s && !(bypass_s && inst_ready_i);
        if (bypass_s) begin
            inst_o    = imem_resp_data_i;
            inst_pc_o = tail_pc_q;
        end else begin
            inst_o    = buf_head_s.inst;
            inst_pc_o = buf_head_s.pc;
        end
    end
`else
    // Every kept response is buffered before it is presented.
    always_comb begin
        inst_valid_s = (buf_count_s != {CntW{1'b0}}) && !redirect_s;
        buf_push_s   = resp_keep_s;
        inst_o       = buf_head_s.inst;
        inst_pc_o    = buf_head_s.pc;
    end
`endif

    assign buf_pop_s        = inst_valid_s && inst_ready_i && (buf_count_s != {CntW{1'b0}});
    assign inst_valid_o     = inst_valid_s;
    assign imem_req_valid_o = req_valid_s;
    assign imem_req_addr_o  = pc_q;

    // State, PC and counter next-state.
    always_comb begin
        case (state_q)
            SBoot:   state_d = SRun;
            SRun:    state_d = SRun;
            default: state_d = SBoot;
        endcase

        if (redirect_s) begin
            pc_d      = target_s;
            tail_pc_d = target_s;
        end else begin
            pc_d      = req_fire_s ? pc_q + Xlen'(4) : pc_q;
            tail_pc_d = resp_keep_s ? tail_pc_q + Xlen'(4) : tail_pc_q;
        end

        outstanding_d = outstanding_q + CntW'(req_fire_s) - CntW'(imem_resp_valid_i);

        // A response arriving with the redirect is already one of the outstanding ones.
        if (redirect_s) begin
            drop_d = outstanding_q - CntW'(imem_resp_valid_i);
        end else if (imem_resp_valid_i && (drop_q != {CntW{1'b0}})) begin
            drop_d = drop_q - CntW'(1);
        end else begin
            drop_d = drop_q;
        end
    end

    // State, PC and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SBoot;
            pc_q          <= ResetVector;
            tail_pc_q     <= ResetVector;
            outstanding_q <= {CntW{1'b0}};
            drop_q        <= {CntW{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tail_pc_q     <= tail_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_buf #(
        .Depth (Depth),
        .CntW  (CntW)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_s),
        .push_i  (buf_push_s),
        .entry_i (resp_entry_s),
        .pop_i   (buf_pop_s),
        .head_o  (buf_head_s),
        .count_o (buf_count_s)
    );

    fetch_chk #(
        .Depth (Depth),
        .CntW  (CntW)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (buf_push_s && !redirect_s),
        .pop_i         (buf_pop_s),
        .count_i       (buf_count_s),
        .drop_i        (drop_q),
        .outstanding_i (outstanding_q)
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-order memory model with adjustable latency,
// redirects, back-pressure on both sides and mid-stream reset.
module tb_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trap_i;
    logic [31:0] trap_vector_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    always #5 clk_i = ~clk_i;

    fetch #(
        .ResetVector (32'h0000_0100),
        .Depth       (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .trap_i            (trap_i),
        .trap_vector_i     (trap_vector_i),
        .branch_i          (branch_i),
        .branch_target_i   (branch_target_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o)
    );

`ifdef FETCH_BYPASS_EN
    localparam logic BypassEn = 1'b1;
`else
    localparam logic BypassEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];
    int          lat    = 1;
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    int          mark;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge handshakes, advance the memory model, drive responses.
    task automatic tick();
        logic        f, r, rs, iv;
        logic [31:0] a, ipc, iin;
        #1;
        f   = imem_req_valid_o && imem_req_ready_i;
        a   = imem_req_addr_o;
        r   = imem_resp_valid_i;
        rs  = rst_i;
        iv  = inst_valid_o && inst_ready_i;
        ipc = inst_pc_o;
        iin = inst_o;
        @(posedge clk_i);
        cyc++;
        if (rs) begin
            pend.delete();
        end else begin
            if (r) void'(pend.pop_front());
            if (f) begin
                pend.push_back('{a, cyc - 1 + lat});
                req_log.push_back(a);
            end
            if (iv) begin
                dlv_pc.push_back(ipc);
                dlv_inst.push_back(iin);
            end
        end
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_data_i  = inst_of(pend[0].addr);
        end else begin
            imem_resp_valid_i = 1'b0;
            imem_resp_data_i  = 32'h0;
        end
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        dlv_pc.delete();
        dlv_inst.delete();
    endtask

    task automatic do_reset();
        trap_i = 1'b0; branch_i = 1'b0;
        inst_ready_i = 1'b1; imem_req_ready_i = 1'b1;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        clear_logs();
    endtask

    initial begin
        rst_i = 1'b1; trap_i = 1'b0; branch_i = 1'b0;
        trap_vector_i = 32'h0; branch_target_i = 32'h0;
        imem_req_ready_i = 1'b1; inst_ready_i = 1'b1;
        imem_resp_valid_i = 1'b0; imem_resp_data_i = 32'h0;

        // Reset state, boot cycle, first request and first delivery timing.
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        rst_i = 1'b0;
        clear_logs();
        chk("boot_no_req", 32'(imem_req_valid_o), 32'd0);
        tick();
        chk("first_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("first_req_addr", imem_req_addr_o, 32'h100);
        tick();
        chk("inst_valid_c2", 32'(inst_valid_o), 32'(BypassEn));
        tick();
        chk("inst_valid_c3", 32'(inst_valid_o), 32'd1);
        chk("inst_pc_c3", inst_pc_o, BypassEn ? 32'h104 : 32'h100);
        repeat (12) tick();
        chk("req_log_len", 32'(req_log.size() >= 3), 32'd1);
        chk("req0", req_log[0], 32'h100);
        chk("req1", req_log[1], 32'h104);
        chk("req2", req_log[2], 32'h108);
        chk("dlv_len", 32'(dlv_pc.size() >= 3), 32'd1);
        chk("dlv_pc0", dlv_pc[0], 32'h100);
        chk("dlv_pc2", dlv_pc[2], 32'h108);
        chk("dlv_inst0", dlv_inst[0], 32'hC0DE_0100);

        // Downstream stall: buffer fills to Depth, requests stop, no loss on release.
        inst_ready_i = 1'b0;
        repeat (10) tick();
        chk("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid_o), 32'd1);
        chk("stall_buffered", 32'(req_log.size() - dlv_pc.size()), 32'd2);
        chk("stall_no_pending", 32'(pend.size()), 32'd0);
        chk("stall_head_pc", inst_pc_o, 32'h100 + 32'(4 * dlv_pc.size()));
        inst_ready_i = 1'b1;
        repeat (12) tick();
        chk("drain_len", 32'(dlv_pc.size() >= 8), 32'd1);
        for (int i = 0; i < dlv_pc.size(); i++) begin
            chk("drain_pc", dlv_pc[i], 32'h100 + 32'(4 * i));
            chk("drain_inst", dlv_inst[i], inst_of(32'h100 + 32'(4 * i)));
        end

        // Memory back-pressure: address held at 0x108 with no PC advance.
        do_reset();
        for (int i = 0; i < 20 && req_log.size() < 2; i++) tick();
        chk("mstall_two_reqs", 32'(req_log.size()), 32'd2);
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mstall_addr_hold", imem_req_addr_o, 32'h108);
        end
        chk("mstall_valid_waiting", 32'(imem_req_valid_o), 32'd1);
        chk("mstall_no_advance", 32'(req_log.size()), 32'd2);
        imem_req_ready_i = 1'b1;
        tick();
        chk("mstall_resume_addr", req_log[2], 32'h108);

        // Branch to 0x2003 with two responses in flight at 3-cycle latency.
        do_reset();
        lat = 3;
        for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
        chk("br_two_inflight", 32'(pend.size()), 32'd2);
        branch_i = 1'b1;
        branch_target_i = 32'h2003;
        #1;
        chk("br_req_forced_low", 32'(imem_req_valid_o), 32'd0);
        chk("br_inst_forced_low", 32'(inst_valid_o), 32'd0);
        tick();
        branch_i = 1'b0;
        #1;
        chk("br_target_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("br_target_addr", imem_req_addr_o, 32'h2000);
        repeat (20) tick();
        chk("br_dlv_len", 32'(dlv_pc.size() >= 2), 32'd1);
        chk("br_first_pc", dlv_pc[0], 32'h2000);
        chk("br_first_inst", dlv_inst[0], 32'hC0DE_2000);
        chk("br_second_pc", dlv_pc[1], 32'h2004);

        // Trap and branch in the same cycle: trap wins.
        do_reset();
        lat = 1;
        repeat (6) tick();
        trap_i = 1'b1; trap_vector_i = 32'h80;
        branch_i = 1'b1; branch_target_i = 32'h400;
        #1;
        chk("tr_inst_forced_low", 32'(inst_valid_o), 32'd0);
        mark = dlv_pc.size();
        tick();
        trap_i = 1'b0; branch_i = 1'b0;
        #1;
        chk("tr_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("tr_req_addr", imem_req_addr_o, 32'h80);
        repeat (10) tick();
        chk("tr_dlv_len", 32'(dlv_pc.size() > mark), 32'd1);
        chk("tr_first_pc", dlv_pc[mark], 32'h80);

        // Reset mid-stream with a full buffer, then restart from the reset vector.
        inst_ready_i = 1'b0;
        repeat (8) tick();
        chk("rs_full_valid", 32'(inst_valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        chk("rs_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rs_inst_valid", 32'(inst_valid_o), 32'd0);
        rst_i = 1'b0;
        inst_ready_i = 1'b1;
        clear_logs();
        tick();
        chk("rs_restart_valid", 32'(imem_req_valid_o), 32'd1);
        chk("rs_restart_addr", imem_req_addr_o, 32'h100);
        repeat (6) tick();
        chk("rs_dlv_len", 32'(dlv_pc.size() >= 1), 32'd1);
        chk("rs_first_pc", dlv_pc[0], 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage. Owns the program counter, issues in-order word requests to instruction memory, buffers returned instructions, and hands them downstream on a valid/ready interface. Accepts PC redirects from the CSR trap unit (trap entry / mret) and from branch resolution, discarding stale in-flight responses.

## Interface
- `ResetVector`, default `'0`: PC of the first fetch after reset; bits [1:0] must be 0.
- `Depth`, default 2: instruction buffer entries; also the maximum number of outstanding requests.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `trap_i` in 1: redirect from the CSR unit (its `raise_trap_o`).
- `trap_vector_i` in Xlen: trap target (its `trap_vector_o`).
- `branch_i` in 1: taken branch/jump redirect.
- `branch_target_i` in Xlen: branch target.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts the request.
- `imem_req_addr_o` out Xlen: word address of the request.
- `imem_resp_valid_i` in 1: one response per accepted request, in order, no earlier than the cycle after acceptance.
- `imem_resp_data_i` in 32: instruction word.
- `inst_valid_o` out 1: `inst_o`/`inst_pc_o` valid.
- `inst_ready_i` in 1: downstream consumes the instruction.
- `inst_o` out 32: instruction.
- `inst_pc_o` out Xlen: PC of `inst_o`.

## Operation
- FSM `state_q`: SBoot and SRun. Reset → SBoot; SBoot → SRun after one cycle unconditionally. No requests in SBoot.
- Counters: `outstanding_q` (accepted, not yet responded), `drop_q` (stale responses still to be discarded), `count_q` (buffer occupancy), each $clog2(Depth+1) bits.
- Issue: `imem_req_valid_o` = SRun && !redirect && (outstanding_q − drop_q + count_q) < Depth. `imem_req_addr_o` = `pc_q`. On handshake, `pc_q` += 4 (wraps modulo 2^Xlen).
- Response: if `drop_q` != 0 or redirect is high, the response is discarded and `drop_q` decrements (when non-zero); else it is written to the buffer tail with its PC (a tail-PC register advances by 4 per kept response).
- Redirect = `trap_i || branch_i`; `trap_i` has priority. Next `pc_q` = selected target with bits [1:0] forced to 0. Same cycle: buffer flushed (count → 0), `inst_valid_o` forced 0, `imem_req_valid_o` forced 0, `drop_q` ← `outstanding_q` − incoming response.
- Output: `inst_valid_o` = count_q != 0 && !redirect; head pops on `inst_valid_o && inst_ready_i`. Simultaneous push and pop keeps count unchanged.
- Buffer can never overflow by construction (credit rule above); a response with a full buffer is a protocol error (assertion).

## Timing
- Reset values: `imem_req_valid_o`=0, `inst_valid_o`=0, `pc_q`=ResetVector, all counters 0.
- First request: second cycle after `rst_i` falls (SBoot cycle, then SRun), address ResetVector.
- Request address is stable while valid is high and not accepted, unless a redirect intervenes.
- Redirect in cycle t → request for the target asserted in t+1.
- Memory latency L cycles → instruction visible L+1 cycles after request acceptance (buffered); see Configuration.
- Reset asserted mid-operation: all state cleared next edge; responses for pre-reset requests must not arrive after reset (memory reset in tandem).

## Configuration
- `FETCH_BYPASS_EN`: when defined, a kept response arriving with count_q == 0 is presented on `inst_o` combinationally the same cycle; if `inst_ready_i` is high it is not written to the buffer. Latency becomes L cycles.
- Without it, every kept response is written to the buffer first; no combinational path from `imem_resp_*` to `inst_*`.

## Structure
- `core_pkg`: `Xlen` (existing), `InstWidth` = 32, `fetch_state_e` {SBoot, SRun}.
- Sub-module `fetch_buf`: Depth-entry circular FIFO of {pc, inst} with push, pop, flush, count output.
- Redirect mux, counters, and PC logic live in `fetch`.

## Test plan
- Reset, ResetVector=0x100, ready always high, 1-cycle memory → requests 0x100, 0x104, 0x108…; `inst_pc_o` sequence matches; first `inst_valid_o` 3 cycles after reset release (2 with bypass).
- `inst_ready_i` low for 10 cycles → exactly Depth requests outstanding/buffered, `imem_req_valid_o` low, no loss; release → in-order drain.
- `imem_req_ready_i` low 5 cycles → address held at 0x108, no PC advance.
- Branch to 0x2003 with 2 responses in flight, 3-cycle latency → both stale responses dropped, next delivered `inst_pc_o` = 0x2000.
- `trap_i` (vector 0x80) and `branch_i` (0x400) same cycle → next request 0x80.
- `rst_i` pulsed mid-stream with buffer full → outputs 0 next cycle; fetch restarts at ResetVector.
